sprite_draw_sched: RTL and testbench
====================================

SPRITE_DRAW_SCHED -- requirements
Module: sprite_draw_sched

Interface
REQ-001 Parameter PANEL_W, default 80: panel width in pixels.
REQ-002 Parameter PANEL_H, default 120: panel height in pixels.
REQ-003 Parameter ROM_LAT, default 1: sprite ROM read latency in cycles (1..3).
REQ-004 Port CLOCK_50  in  1  system clock; reset reset_n, asynchronous, active-low; clock CLOCK_50.
REQ-005 Port reset_n  in  1  asynchronous active-low reset.
REQ-006 Port req  in  2  draw requests; bit0 = computer panel (x 0..79), bit1 = user panel (x 80..159).
REQ-007 Port choice_c  in  2  computer shape: 00 rock, 01 scissor, 10/11 paper.
REQ-008 Port choice_u  in  2  user shape, same encoding as choice_c.
REQ-009 Port ack  out  2  one-cycle grant pulse, at most one bit set.
REQ-010 Port busy  out  1  high while a draw is in progress.
REQ-011 Port done  out  1  one-cycle pulse when a draw completes.
REQ-012 Port rom_addr  out  15  sprite ROM address.
REQ-013 Port q_r, q_s, q_p  in  1 each  rock, scissor and paper ROM pixel outputs.
REQ-014 Port vga_x  out  8  plot x coordinate.
REQ-015 Port vga_y  out  7  plot y coordinate.
REQ-016 Port vga_colour  out  3  plot colour.
REQ-017 Port vga_plot  out  1  plot strobe to the VGA adapter.

Function
REQ-018 FSM states: IDLE, SCAN, FLUSH, DONE.
REQ-019 IDLE with req!=0 at edge T: ack bit set at T+1, panel and shape latched, busy=1, enter SCAN.
REQ-020 Latched shape/panel hold for the whole draw; choice or req changes during busy are ignored.
REQ-021 SCAN: pixel counter x 0..PANEL_W-1 (inner), y 0..PANEL_H-1 (outer), one pixel per cycle, first address issued at T+1.
REQ-022 rom_addr = y*160 + xs, xs = x + (panel ? PANEL_W : 0), computed modulo 2^15.
REQ-023 ROM output selected by the latched shape; codes 10 and 11 both select q_p.
REQ-024 vga_plot for pixel k asserts at cycle T+1+k+ROM_LAT, with vga_x=xs and vga_y=y delayed ROM_LAT cycles to align with the ROM data.
REQ-025 Colour: q=0 -> 3'b010 green; q=1 -> 3'b111 for panel 0, 3'b000 for panel 1.
REQ-026 After the last address (x=PANEL_W-1, y=PANEL_H-1), FLUSH lasts ROM_LAT cycles, then DONE.
REQ-027 DONE: done=1 for one cycle, busy=1 in that cycle, then IDLE; a new request is acceptable in the next cycle.
REQ-028 One draw spans PANEL_W*PANEL_H+ROM_LAT+1 cycles from ack to done inclusive (9602 at defaults).
REQ-029 vga_plot=0 in IDLE, in DONE, and in the first ROM_LAT cycles of SCAN.

Reset
REQ-030 Asserting reset_n low at any time, including mid-draw: state=IDLE, ack=0, busy=0, done=0, vga_plot=0, rom_addr=0, vga_x=0, vga_y=0, vga_colour=0, counters=0, arbitration pointer=panel 0; the partial draw is abandoned.

Configuration
REQ-031 With SPRITE_SCHED_RR_EN defined: round-robin arbitration; on simultaneous requests, grant the panel not granted last (panel 0 after reset).
REQ-032 Without SPRITE_SCHED_RR_EN: fixed priority, panel 0 always wins simultaneous requests.

Structure
REQ-033 Package sprite_pkg holds shape codes, colour constants (GREEN, WHITE, BLACK), screen width 160, and the FSM state enum.
REQ-034 Address generation (shift-add y*128+y*32+xs) lives in sub-module sprite_addr_gen; pipeline alignment and the FSM stay in the top level.

Verification
REQ-035 req=01, choice_c=01 -> ack=01 next cycle; first rom_addr=0; first plot at (0,0) one cycle later; done after 9602 cycles; exactly 9600 plots.
REQ-036 req=10, choice_u=10, q_p forced 1 -> plots at x 80..159 only, all vga_colour=000; final rom_addr=119*160+159=19199.
REQ-037 req=11 in IDLE after reset -> ack=01; hold req=10 -> ack=10 immediately after done; with RR, a second simultaneous 11 -> ack=10.
REQ-038 Without SPRITE_SCHED_RR_EN, req=11 held -> ack=01 for every grant.
REQ-039 reset_n low at pixel 5000 -> all outputs 0 in the same cycle; after release req=01 -> the draw restarts at (0,0).
REQ-040 choice_c toggled mid-draw, ROM_LAT=2 -> shape unchanged, plot-to-address alignment offset of 2 cycles, done after 9603 cycles.

Source files
------------

// File: rtl/sprite_pkg.sv
// sprite_pkg: shape codes, plot colours, screen geometry and FSM states
// shared by the sprite draw scheduler.
package sprite_pkg;

    localparam logic [1:0] SHAPE_ROCK    = 2'b00;
    localparam logic [1:0] SHAPE_SCISSOR = 2'b01;
    localparam logic [1:0] SHAPE_PAPER   = 2'b10;

    localparam logic [2:0] GREEN = 3'b010;
    localparam logic [2:0] WHITE = 3'b111;
    localparam logic [2:0] BLACK = 3'b000;

    localparam int SCREEN_W = 160;

    typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_e;

    // Codes 10 and 11 both mean paper, so only the top bit matters there.
    function automatic logic shape_pix(logic [1:0] s, logic r, logic sc, logic p);
        return (s[1] == SHAPE_PAPER[1]) ? p : (s == SHAPE_SCISSOR) ? sc : (s == SHAPE_ROCK) ? r : p;
    endfunction

endpackage

// File: rtl/sprite_draw_sched_if.sv
// sprite_draw_sched_if: request/grant, sprite ROM and VGA plot signals of the
// draw scheduler; slave is the scheduler side, master the surrounding system.
interface sprite_draw_sched_if;

    logic [1:0]  req, choice_c, choice_u, ack;
    logic        busy, done;
    logic [14:0] rom_addr;
    logic        q_r, q_s, q_p;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;

    modport master (
        output req, choice_c, choice_u, q_r, q_s, q_p,
        input  ack, busy, done, rom_addr, vga_x, vga_y, vga_colour, vga_plot
    );

    modport slave (
        input  req, choice_c, choice_u, q_r, q_s, q_p,
        output ack, busy, done, rom_addr, vga_x, vga_y, vga_colour, vga_plot
    );

endinterface

// File: rtl/sprite_addr_gen.sv
// sprite_addr_gen: screen x of the current pixel and its sprite ROM address,
// y*SCREEN_W + xs built from two shifted copies of y.
module sprite_addr_gen
    import sprite_pkg::*;
#(
    parameter int PANEL_W = 80
) (
    input  logic [7:0]  x,
    input  logic [6:0]  y,
    input  logic        panel,
    output logic [7:0]  xs,
    output logic [14:0] addr
);

    // 160 = 128 + 32
    localparam int HI = $clog2(SCREEN_W) - 1;
    localparam int LO = $clog2(SCREEN_W - (1 << HI));

    assign xs   = x + (panel ? 8'(PANEL_W) : 8'd0);
    assign addr = (15'(y) << HI) + (15'(y) << LO) + 15'(xs);

endmodule

// File: rtl/sprite_draw_sched.sv
// sprite_draw_sched: grants one panel draw at a time, scans its pixels through
// the sprite ROM and plots them. Define SPRITE_SCHED_RR_EN for round-robin grants.
module sprite_draw_sched
    import sprite_pkg::*;
#(
    parameter int PANEL_W = 80,
    parameter int PANEL_H = 120,
    parameter int ROM_LAT = 1
) (
    input logic CLOCK_50,
    input logic reset_n,
    sprite_draw_sched_if.slave bus
);

    state_e      state_q, state_d;
    logic [1:0]  ack_q, ack_d, shape_q, shape_d, fl_q, fl_d;
    logic        panel_q, panel_d, gnt, last_px, x_end, pix;
    logic [7:0]  x_q, x_d, xs;
    logic [6:0]  y_q, y_d;
    logic [7:0]  xp_q [ROM_LAT], xp_d [ROM_LAT];
    logic [6:0]  yp_q [ROM_LAT], yp_d [ROM_LAT];
    logic [ROM_LAT-1:0] vp_q, vp_d;

    sprite_addr_gen #(.PANEL_W(PANEL_W)) u_addr (
        .x(x_q), .y(y_q), .panel(panel_q), .xs(xs), .addr(bus.rom_addr)
    );

`ifdef SPRITE_SCHED_RR_EN
    logic pri_q, pri_d;
    assign gnt   = &bus.req ? pri_q : bus.req[1];
    assign pri_d = (state_q == IDLE && |bus.req) ? ~gnt : pri_q;
    always_ff @(posedge CLOCK_50 or negedge reset_n)
        if (!reset_n) pri_q <= 1'b0;
        else pri_q <= pri_d;
`else
    assign gnt = bus.req[1] & ~bus.req[0];
`endif

    assign x_end   = x_q == 8'(PANEL_W - 1);
    assign last_px = x_end && y_q == 7'(PANEL_H - 1);

    always_comb begin
        state_d = state_q;
        ack_d   = 2'b00;
        shape_d = shape_q;
        panel_d = panel_q;
        x_d     = x_q;
        y_d     = y_q;
        fl_d    = fl_q;
        unique case (state_q)
            IDLE: if (|bus.req) begin
                state_d = SCAN;
                ack_d   = gnt ? 2'b10 : 2'b01;
                panel_d = gnt;
                shape_d = gnt ? bus.choice_u : bus.choice_c;
            end
            SCAN: begin
                x_d     = x_end ? 8'd0 : x_q + 8'd1;
                y_d     = !x_end ? y_q : last_px ? 7'd0 : y_q + 7'd1;
                fl_d    = 2'd0;
                state_d = last_px ? FLUSH : SCAN;
            end
            FLUSH: begin
                fl_d    = fl_q + 2'd1;
                state_d = (fl_q == 2'(ROM_LAT - 1)) ? DONE : FLUSH;
            end
            DONE: state_d = IDLE;
        endcase
    end

    // Coordinates and valid travel alongside the ROM read so they meet its data.
    always_comb begin
        xp_d[0] = xs;
        yp_d[0] = y_q;
        vp_d    = '0;
        vp_d[0] = state_q == SCAN;
        for (int i = 1; i < ROM_LAT; i++) begin
            xp_d[i] = xp_q[i-1];
            yp_d[i] = yp_q[i-1];
            vp_d[i] = vp_q[i-1];
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ack_q   <= 2'b00;
            shape_q <= 2'b00;
            panel_q <= 1'b0;
            x_q     <= 8'd0;
            y_q     <= 7'd0;
            fl_q    <= 2'd0;
            xp_q    <= '{default: '0};
            yp_q    <= '{default: '0};
            vp_q    <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            shape_q <= shape_d;
            panel_q <= panel_d;
            x_q     <= x_d;
            y_q     <= y_d;
            fl_q    <= fl_d;
            xp_q    <= xp_d;
            yp_q    <= yp_d;
            vp_q    <= vp_d;
        end
    end

    assign pix            = shape_pix(shape_q, bus.q_r, bus.q_s, bus.q_p);
    assign bus.ack        = ack_q;
    assign bus.busy       = state_q != IDLE;
    assign bus.done       = state_q == DONE;
    assign bus.vga_plot   = vp_q[ROM_LAT-1];
    assign bus.vga_x      = xp_q[ROM_LAT-1];
    assign bus.vga_y      = yp_q[ROM_LAT-1];
    assign bus.vga_colour = !vp_q[ROM_LAT-1] ? BLACK : !pix ? GREEN : panel_q ? BLACK : WHITE;

endmodule

// File: tb/tb_sprite_draw_sched.sv
// tb_sprite_draw_sched: random stimulus into two schedulers (ROM_LAT 1 and 2),
// each checked every cycle against a draw-position model.
module tb_sprite_draw_sched;

    localparam int W = 80, H = 120, N = W * H;
`ifdef SPRITE_SCHED_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct packed {
        logic [1:0]  ack;
        logic        busy, done, plot;
        logic [14:0] addr;
        logic [7:0]  x;
        logic [6:0]  y;
        logic [2:0]  col;
    } obs_t;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic [1:0] req = 2'b00, choice_c = 2'b00, choice_u = 2'b00;
    logic       q_r = 1'b0, q_s = 1'b0, q_p = 1'b0;

    always #5 clk = ~clk;

    sprite_draw_sched_if bus0 ();
    sprite_draw_sched_if bus1 ();

    assign bus0.req = req;  assign bus0.choice_c = choice_c;  assign bus0.choice_u = choice_u;
    assign bus0.q_r = q_r;  assign bus0.q_s = q_s;            assign bus0.q_p = q_p;
    assign bus1.req = req;  assign bus1.choice_c = choice_c;  assign bus1.choice_u = choice_u;
    assign bus1.q_r = q_r;  assign bus1.q_s = q_s;            assign bus1.q_p = q_p;

    sprite_draw_sched #(.ROM_LAT(1)) u0 (.CLOCK_50(clk), .reset_n(rst_n), .bus(bus0));
    sprite_draw_sched #(.ROM_LAT(2)) u1 (.CLOCK_50(clk), .reset_n(rst_n), .bus(bus1));

    obs_t o0, o1;
    assign o0 = {bus0.ack, bus0.busy, bus0.done, bus0.vga_plot, bus0.rom_addr, bus0.vga_x, bus0.vga_y, bus0.vga_colour};
    assign o1 = {bus1.ack, bus1.busy, bus1.done, bus1.vga_plot, bus1.rom_addr, bus1.vga_x, bus1.vga_y, bus1.vga_colour};

    int passed = 0, total = 0, cyc = 0;
    int mk[2] = '{-1, -1};
    logic mpan[2] = '{1'b0, 1'b0};
    logic mpri[2] = '{1'b0, 1'b0};
    logic [1:0] mshape[2] = '{2'b00, 2'b00};
    int draws[2] = '{0, 0};
    int ack_cyc[2] = '{0, 0};
    int nplot[2] = '{0, 0};
    int maxaddr0 = 0, badx0 = 0, badc0 = 0;
    int acks0[$];
    bit after_rst = 1'b0, want_first = 1'b0;

    task automatic chk(string name, longint got, longint exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    // Expected outputs follow from k, the cycle index since the grant:
    // pixel k addressed at k, plotted at k+L, done at N+L.
    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            obs_t g, e;
            int k, j, l;
            logic qv, gn;
            l = i + 1;
            g = (i == 0) ? o0 : o1;
            if (!rst_n) begin
                total++;
                if (g === '0) passed++;
                else $display("FAIL reset_dut%0d: got %h expected 0", i, g);
                mk[i] = -1;
                mpri[i] = 1'b0;
            end else begin
                k = mk[i];
                e = '0;
                e.ack  = (k == 0) ? (mpan[i] ? 2'b10 : 2'b01) : 2'b00;
                e.busy = k >= 0;
                e.done = k == N + l;
                e.plot = k >= l && k < N + l;
                if (k >= 0 && k < N) e.addr = 15'(k / W * 160 + k % W + (mpan[i] ? W : 0));
                else g.addr = '0;
                if (e.plot) begin
                    j = k - l;
                    qv = (mshape[i] == 2'b00) ? q_r : (mshape[i] == 2'b01) ? q_s : q_p;
                    e.x = 8'(j % W + (mpan[i] ? W : 0));
                    e.y = 7'(j / W);
                    e.col = !qv ? 3'b010 : mpan[i] ? 3'b000 : 3'b111;
                end else begin
                    g.x = '0;
                    g.y = '0;
                    g.col = '0;
                end
                total++;
                if (g === e) passed++;
                else $display("FAIL cycle%0d_dut%0d: got ack=%b busy=%b done=%b plot=%b addr=%0d x=%0d y=%0d col=%b expected ack=%b busy=%b done=%b plot=%b addr=%0d x=%0d y=%0d col=%b",
                              cyc, i, g.ack, g.busy, g.done, g.plot, g.addr, g.x, g.y, g.col,
                              e.ack, e.busy, e.done, e.plot, e.addr, e.x, e.y, e.col);
                if (g.ack != 2'b00) begin
                    ack_cyc[i] = cyc;
                    nplot[i] = 0;
                    if (i == 0) begin
                        acks0.push_back(int'(g.ack));
                        maxaddr0 = 0; badx0 = 0; badc0 = 0;
                        if (after_rst) begin
                            chk("restart_first_addr", g.addr, 0);
                            after_rst = 1'b0;
                            want_first = 1'b1;
                        end
                    end
                end
                if (i == 0 && g.busy && int'(g.addr) > maxaddr0) maxaddr0 = int'(g.addr);
                if (g.plot) begin
                    nplot[i]++;
                    if (i == 0 && g.x < 8'd80) badx0++;
                    if (i == 0 && g.col != 3'b000) badc0++;
                    if (i == 0 && want_first) begin
                        chk("restart_first_plot_xy", {g.x, g.y}, 0);
                        want_first = 1'b0;
                    end
                end
                if (g.done) begin
                    chk(i == 0 ? "draw_len_lat1" : "draw_len_lat2", cyc - ack_cyc[i] + 1, i == 0 ? 9602 : 9603);
                    chk("plot_count", nplot[i], 9600);
                    if (i == 0 && draws[0] == 2) begin
                        chk("user_panel_max_addr", maxaddr0, 19199);
                        chk("user_panel_x_below_80", badx0, 0);
                        chk("user_panel_nonblack", badc0, 0);
                    end
                end
                if (k == N + l) begin
                    mk[i] = -1;
                    draws[i]++;
                end else if (k >= 0) mk[i] = k + 1;
                else if (req != 2'b00) begin
                    gn = (req == 2'b11) ? (RR ? mpri[i] : 1'b0) : req[1];
                    mpri[i] = ~gn;
                    mpan[i] = gn;
                    mshape[i] = gn ? choice_u : choice_c;
                    mk[i] = 0;
                end
            end
        end
    end

    task automatic drive(int m);
        q_r = 1'($urandom);
        q_s = 1'($urandom);
        q_p = (m == 1) ? 1'b1 : 1'($urandom);
        choice_c = 2'($urandom);
        choice_u = 2'($urandom);
        case (m)
            0: req = 2'b11;
            1: begin req = 2'b10; choice_u = 2'b10; end
            2: req = 2'($urandom);
            default: begin req = 2'b01; choice_c = 2'b01; end
        endcase
    endtask

    task automatic run(int m, int target, int budget, string name);
        int n = 0;
        drive(m);
        while (draws[0] < target && n < budget) begin
            @(posedge clk);
            #1;
            if (draws[0] < target) drive(m);
            n++;
        end
        chk(name, draws[0] >= target, 1);
    endtask

    initial begin
        int n = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        run(0, 2, 20000, "both_req_draws_complete");
        run(1, 3, 10000, "user_paper_draw_completes");
        run(2, 4, 12000, "random_req_draw_completes");
        while (mk[0] != 5000 && n < 12000) begin
            @(posedge clk);
            #1;
            if (mk[0] != 5000) drive(2);
            n++;
        end
        chk("reached_pixel_5000", mk[0], 5000);
        rst_n = 1'b0;
        #1;
        chk("midreset_outputs_dut0", o0, 0);
        chk("midreset_outputs_dut1", o1, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        after_rst = 1'b1;
        run(3, 5, 10000, "restart_draw_completes");
        chk("grant_count", acks0.size() >= 3, 1);
        if (acks0.size() >= 3) begin
            chk("first_grant_both_req", acks0[0], 1);
            chk("second_grant_both_req", acks0[1], RR ? 2 : 1);
            chk("grant_after_done_req10", acks0[2], 2);
        end
        chk("lat2_draws_seen", draws[1] >= 1, 1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
